heart_rate_bcd: RTL and testbench
=================================

HEART_RATE_BCD -- requirements
Module: heart_rate_bcd

Interface
REQ-001 SHALL have parameter BIN_W, default 12, width of the binary heart-rate input.
REQ-002 SHALL have parameter SAT_VALUE, default 999, largest displayable value; larger inputs clamp to it.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low; reset asserts when reset=0.
REQ-005 SHALL have port bin_in  input  BIN_W  unsigned beats-per-minute value from the peak-counting stage.
REQ-006 SHALL have port bin_valid  input  1  one-cycle strobe qualifying bin_in.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when new digits are presented.
REQ-009 SHALL have port digit0, digit1, digit2  output  4 each  BCD ones, tens, hundreds; held between conversions.
REQ-010 SHALL have port blank1, blank2  output  1 each  leading-zero blank flags for tens and hundreds.
REQ-011 SHALL have port sat  output  1  high when the last converted input exceeded SAT_VALUE.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 IDLE: on bin_valid=1, capture min(bin_in, SAT_VALUE) into shift register, clear 12-bit BCD accumulator, record sat flag, go to SHIFT with iteration counter = 0.
REQ-014 SHIFT: exactly BIN_W cycles; each cycle add 3 to every BCD nibble >= 5, then shift {BCD, bin} left one bit; after iteration BIN_W-1 go to DONE.
REQ-015 DONE: one cycle; register digit0..2, blank1, blank2, sat from accumulator; done=1 for this cycle only; go to IDLE.
REQ-016 Latency: bin_valid sampled at edge E -> done high in the cycle after edge E+BIN_W+1 (cycle 14 for BIN_W=12); outputs change on that same edge.
REQ-017 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-018 bin_valid while busy: value stored in a one-deep pending register; a later strobe overwrites it (last wins); no strobe is lost beyond that.
REQ-019 Pending value SHALL launch from IDLE on the cycle after DONE, exactly as a fresh bin_valid; pending cleared on launch.
REQ-020 bin_valid in the DONE cycle SHALL go to the pending register.
REQ-021 blank2 = (digit2==0); blank1 = (digit2==0 && digit1==0); digit0 never blanked.
REQ-022 Arithmetic unsigned; clamp compare at full BIN_W width; BCD accumulator 12 bits (thousands nibble never needed since input <= 999).
REQ-023 Outputs digit0..2, blank*, sat SHALL change only in DONE or reset.

Reset
REQ-024 reset=0 SHALL immediately force: state IDLE, busy=0, done=0, digits 0, blank1=1, blank2=1, sat=0, pending empty, counter 0.
REQ-025 Reset mid-conversion SHALL abort it; no done pulse for the aborted value; pending discarded.
REQ-026 First conversion after reset release SHALL behave identically to any other.

Verification
REQ-027 bin_in=0 strobe -> done in cycle 14; digits 0/0/0, blank1=1, blank2=1, sat=0.
REQ-028 bin_in=72 -> digit2=0, digit1=7, digit0=2, blank2=1, blank1=0; busy high for 13 cycles.
REQ-029 bin_in=100 -> 1/0/0, blank1=0, blank2=0 (inner zero not blanked); bin_in=4095 -> 9/9/9, sat=1.
REQ-030 Strobe 120, then 60 and 90 while busy -> done with 120, then done with 90 at 14 cycles after first done; 60 never appears.
REQ-031 Strobe 150, assert reset at SHIFT iteration 5 -> outputs reset values, no done; after release strobe 66 -> 0/6/6 normal latency.
REQ-032 Randomized 0..4095 strobes with random gaps -> every done matches min(v, 999) digits, done never high two consecutive cycles.

Source files
------------

// File: rtl/heart_rate_bcd.sv
// heart_rate_bcd: converts a binary beats-per-minute value into three BCD
// digits using a shift-and-add-3 (double dabble) engine, one bit per cycle.
// Inputs above SAT_VALUE are clamped and flagged. A strobe that arrives
// while a conversion is running is parked in a one-deep pending slot, where
// the newest value wins.
module heart_rate_bcd #(
  parameter int BIN_W     = 12,
  parameter int SAT_VALUE = 999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic             blank1,
  output logic             blank2,
  output logic             sat
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int               CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BIN_W-1:0] SAT_LIM = BIN_W'(SAT_VALUE);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BIN_W - 1);

  state_t           state_reg, state_next;
  logic [BIN_W-1:0] shift_reg;
  logic [11:0]      bcd_reg;
  logic [11:0]      bcd_adj;
  logic [CNT_W-1:0] cnt_reg;
  logic             sat_cap_reg;
  logic             pend_valid_reg;
  logic [BIN_W-1:0] pend_data_reg;

  logic             launch;
  logic [BIN_W-1:0] launch_data;
  logic             store;

  // A conversion starts from IDLE with either the parked value or a fresh
  // strobe; the parked value has priority because it arrived first.
  assign launch      = (state_reg == IDLE) && (pend_valid_reg || bin_valid);
  assign launch_data = pend_valid_reg ? pend_data_reg : bin_in;
  // A strobe is parked whenever it cannot launch directly.
  assign store       = bin_valid && ((state_reg != IDLE) || pend_valid_reg);

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and the busy flag.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (launch) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt_reg == CNT_END) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy       = 1'b0;
      end
    endcase
  end

  // Conversion datapath and the registered result presented from DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg   <= '0;
      bcd_reg     <= '0;
      cnt_reg     <= '0;
      sat_cap_reg <= 1'b0;
      done        <= 1'b0;
      digit0      <= 4'd0;
      digit1      <= 4'd0;
      digit2      <= 4'd0;
      blank1      <= 1'b1;
      blank2      <= 1'b1;
      sat         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (launch) begin
            shift_reg   <= (launch_data > SAT_LIM) ? SAT_LIM : launch_data;
            sat_cap_reg <= (launch_data > SAT_LIM);
            bcd_reg     <= '0;
            cnt_reg     <= '0;
          end
        end
        SHIFT: begin
          bcd_reg   <= {bcd_adj[10:0], shift_reg[BIN_W-1]};
          shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
          cnt_reg   <= cnt_reg + 1'b1;
        end
        DONE: begin
          digit0 <= bcd_reg[3:0];
          digit1 <= bcd_reg[7:4];
          digit2 <= bcd_reg[11:8];
          blank2 <= (bcd_reg[11:8] == 4'd0);
          blank1 <= (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0);
          sat    <= sat_cap_reg;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One-deep pending slot: newest parked strobe wins, emptied on launch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
    end else if (store) begin
      pend_valid_reg <= 1'b1;
      pend_data_reg  <= bin_in;
    end else if (launch && pend_valid_reg) begin
      pend_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_heart_rate_bcd.sv
// Testbench for heart_rate_bcd: table of single conversions, hand-written
// sequences for pending/overwrite, DONE-cycle strobe and reset abort, then
// random values with random gaps checked against an arithmetic model.
module tb_heart_rate_bcd;

  logic        clk;
  logic        reset;
  logic [11:0] bin_in;
  logic        bin_valid;
  logic        busy;
  logic        done;
  logic [3:0]  digit0, digit1, digit2;
  logic        blank1, blank2, sat;

  int n_checks = 0;
  int n_fail   = 0;

  heart_rate_bcd #(.BIN_W(12), .SAT_VALUE(999)) dut (
    .clk(clk), .reset(reset), .bin_in(bin_in), .bin_valid(bin_valid),
    .busy(busy), .done(done), .digit0(digit0), .digit1(digit1),
    .digit2(digit2), .blank1(blank1), .blank2(blank2), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v;
    int d2;
    int d1;
    int d0;
    int b1;
    int b2;
    int s;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the sampling edge.
  task automatic strobe(input int v);
    bin_in    = 12'(v);
    bin_valid = 1'b1;
    @(posedge clk); #1;
    bin_valid = 1'b0;
  endtask

  // Counts cycles from the sampling edge (cycle 1) until done is seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic check_result(input int v, input int d2, input int d1, input int d0,
                              input int b1, input int b2, input int s);
    chk("digit2", digit2, d2);
    chk("digit1", digit1, d1);
    chk("digit0", digit0, d0);
    chk("blank1", blank1, b1);
    chk("blank2", blank2, b2);
    chk("sat", sat, s);
    $display("conv in=%0d -> %0d%0d%0d blank=%0d%0d sat=%0d", v, digit2, digit1, digit0,
             blank2, blank1, sat);
  endtask

  // Single conversion with latency, busy length and one-cycle done checks.
  task automatic run_one(input int v, input int d2, input int d1, input int d0,
                         input int b1, input int b2, input int s);
    int lat, bc;
    strobe(v);
    wait_done(lat, bc);
    chk("latency", lat, 14);
    chk("busy_cycles", bc, 13);
    check_result(v, d2, d1, d0, b1, b2, s);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  // Launch v0, then optional strobes at cycles c1/c2; record first two dones.
  task automatic seq(input int v0, input int c1, input int v1, input int c2, input int v2,
                     output int nd, output int dc0, output int dv0,
                     output int dc1, output int dv1, output int dbl);
    int cyc;
    logic prev_done;
    nd = 0; dc0 = 0; dv0 = -1; dc1 = 0; dv1 = -1; dbl = 0;
    prev_done = 1'b0;
    strobe(v0);
    cyc = 1;
    while (cyc < 45) begin
      if (cyc == c1) begin
        bin_in = 12'(v1); bin_valid = 1'b1;
      end else if (cyc == c2) begin
        bin_in = 12'(v2); bin_valid = 1'b1;
      end else begin
        bin_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done && prev_done) dbl++;
      prev_done = done;
      if (done) begin
        if (nd == 0) begin
          dc0 = cyc; dv0 = digit2 * 100 + digit1 * 10 + digit0;
        end else if (nd == 1) begin
          dc1 = cyc; dv1 = digit2 * 100 + digit1 * 10 + digit0;
        end
        nd++;
        $display("seq done cycle=%0d value=%0d%0d%0d", cyc, digit2, digit1, digit0);
      end
    end
    bin_valid = 1'b0;
  endtask

  initial begin
    int nd, dc0, dv0, dc1, dv1, dbl;
    int lat, bc, v, e, ndone;

    vecs[0] = '{v: 0,    d2: 0, d1: 0, d0: 0, b1: 1, b2: 1, s: 0};
    vecs[1] = '{v: 72,   d2: 0, d1: 7, d0: 2, b1: 0, b2: 1, s: 0};
    vecs[2] = '{v: 100,  d2: 1, d1: 0, d0: 0, b1: 0, b2: 0, s: 0};
    vecs[3] = '{v: 4095, d2: 9, d1: 9, d0: 9, b1: 0, b2: 0, s: 1};
    vecs[4] = '{v: 999,  d2: 9, d1: 9, d0: 9, b1: 0, b2: 0, s: 0};
    vecs[5] = '{v: 1000, d2: 9, d1: 9, d0: 9, b1: 0, b2: 0, s: 1};
    vecs[6] = '{v: 5,    d2: 0, d1: 0, d0: 5, b1: 1, b2: 1, s: 0};
    vecs[7] = '{v: 10,   d2: 0, d1: 1, d0: 0, b1: 0, b2: 1, s: 0};
    vecs[8] = '{v: 505,  d2: 5, d1: 0, d0: 5, b1: 0, b2: 0, s: 0};
    vecs[9] = '{v: 59,   d2: 0, d1: 5, d0: 9, b1: 0, b2: 1, s: 0};

    reset     = 1'b0;
    bin_valid = 1'b0;
    bin_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_digits", {digit2, digit1, digit0}, 0);
    chk("rst_blank1", blank1, 1);
    chk("rst_blank2", blank2, 1);
    chk("rst_sat", sat, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_one(vecs[i].v, vecs[i].d2, vecs[i].d1, vecs[i].d0,
              vecs[i].b1, vecs[i].b2, vecs[i].s);

    // 120 runs; 60 then 90 arrive while busy; 90 overwrites 60.
    seq(120, 3, 60, 7, 90, nd, dc0, dv0, dc1, dv1, dbl);
    chk("pend_ndone", nd, 2);
    chk("pend_first_cycle", dc0, 14);
    chk("pend_first_value", dv0, 120);
    chk("pend_second_cycle", dc1, 28);
    chk("pend_second_value", dv1, 90);
    chk("pend_no_double_done", dbl, 0);

    // Strobe during the DONE cycle (cycle 13) is parked and launched next.
    seq(200, 13, 45, -1, 0, nd, dc0, dv0, dc1, dv1, dbl);
    chk("donecyc_ndone", nd, 2);
    chk("donecyc_first_value", dv0, 200);
    chk("donecyc_second_cycle", dc1, 28);
    chk("donecyc_second_value", dv1, 45);

    // Reset during shift iteration 5, with a value parked; both are dropped.
    strobe(150);
    repeat (2) @(posedge clk);
    #1;
    bin_in = 12'd77; bin_valid = 1'b1;
    @(posedge clk); #1;
    bin_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_digits", {digit2, digit1, digit0}, 0);
    chk("abort_blank1", blank1, 1);
    chk("abort_blank2", blank2, 1);
    chk("abort_sat", sat, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_activity", ndone, 0);
    run_one(66, 0, 6, 6, 0, 1, 0);

    // Random values with random idle gaps, checked against a decimal model.
    for (int i = 0; i < 25; i++) begin
      v = int'($urandom_range(0, 4095));
      e = (v > 999) ? 999 : v;
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      strobe(v);
      wait_done(lat, bc);
      chk("rand_latency", lat, 14);
      check_result(v, e / 100, (e / 10) % 10, e % 10,
                   (e < 10) ? 1 : 0, (e < 100) ? 1 : 0, (v > 999) ? 1 : 0);
      @(posedge clk); #1;
      chk("rand_done_one_cycle", done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
